// File: rtl/char_grab.sv
// char_grab: samples an 8x8 block of 16-bit pixels from a framebuffer through a
// pipelined Avalon-MM read master and builds a 64-bit "pixel == match colour" bitmap.
module char_grab #(
    parameter int XRES    = 640,
    parameter int MAX_OUT = 4
) (
    input  logic        clock,
    input  logic        clock_areset_n,
    // Avalon-MM slave (register file)
    input  logic [3:0]  s_address,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    input  logic        s_read,
    input  logic        s_write,
    output logic        s_waitrequest,
    output logic        s_irq,
    // Avalon-MM pipelined read master (framebuffer)
    output logic [31:0] m_address,
    output logic [1:0]  m_byteenable,
    output logic        m_read,
    input  logic [15:0] m_readdata,
    input  logic        m_readdatavalid,
    input  logic        m_waitrequest
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] ROW_STEP  = 32'(2 * XRES);
    localparam logic [3:0]  OUT_LIMIT = 4'(MAX_OUT);
    localparam logic [6:0]  NUM_PIX   = 7'd64;
    localparam logic [6:0]  LAST_PIX  = 7'd63;

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_PTR    = 4'd1;
    localparam logic [3:0] REG_MATCH  = 4'd2;
    localparam logic [3:0] REG_BMP_LO = 4'd3;
    localparam logic [3:0] REG_BMP_HI = 4'd4;
    localparam logic [3:0] REG_IRQCLR = 4'd5;

    state_t      state_reg;
    state_t      state_next;

    // programmed registers (visible on the slave) and per-job latched copies
    logic        irq_en_reg;
    logic [31:0] pointer_reg;
    logic [15:0] match_reg;
    logic [15:0] job_match_reg;
    logic        irq_reg;

    // master-side bookkeeping
    logic [31:0] addr_reg;
    logic [31:0] row_base_reg;
    logic [2:0]  col_reg;
    logic [6:0]  issue_cnt_reg;
    logic [6:0]  ret_cnt_reg;
    logic [3:0]  out_cnt_reg;
    logic [63:0] bitmap_reg;
    logic [63:0] bitmap_next;

    // slave read handshake
    logic        rd_phase_reg;
    logic [31:0] rdata_reg;
    logic [31:0] rd_mux;

    logic        busy;
    logic        wr_ctrl;
    logic        start_job;
    logic        clear_irq;
    logic        accept;
    logic        rvalid;
    logic        last_ret;
    logic        pix_hit;

    assign busy       = (state_reg != IDLE);
    assign wr_ctrl    = s_write && (s_address == REG_CTRL);
    assign start_job  = wr_ctrl && s_writedata[0] && (state_reg == IDLE);
    assign clear_irq  = s_write && (s_address == REG_IRQCLR) && s_writedata[0];
    assign accept     = m_read && !m_waitrequest;
    // responses arriving while idle belong to no job and are dropped
    assign rvalid     = m_readdatavalid && busy;
    assign last_ret   = rvalid && (ret_cnt_reg == LAST_PIX);
    assign pix_hit    = (m_readdata == job_match_reg);

    assign m_address     = addr_reg;
    assign m_byteenable  = 2'b11;
    assign s_irq         = irq_reg;
    assign s_readdata    = rdata_reg;
    assign s_waitrequest = s_read && !rd_phase_reg;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // m_read depends only on registered state so it cannot drop under waitrequest
    always_comb begin
        state_next = state_reg;
        m_read     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_job) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                m_read = (issue_cnt_reg < NUM_PIX) && (out_cnt_reg < OUT_LIMIT);
                if (accept && (issue_cnt_reg == LAST_PIX)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_ret) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file writes and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            irq_en_reg  <= 1'b0;
            pointer_reg <= 32'd0;
            match_reg   <= 16'd0;
        end else if (s_write) begin
            case (s_address)
                REG_CTRL:  irq_en_reg  <= s_writedata[2];
                REG_PTR:   pointer_reg <= s_writedata;
                REG_MATCH: match_reg   <= s_writedata[15:0];
                default: ;
            endcase
        end
    end

    // completion wins over a coincident clear so the event is never lost
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            irq_reg <= 1'b0;
        end else if (last_ret && irq_en_reg) begin
            irq_reg <= 1'b1;
        end else if (clear_irq) begin
            irq_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Slave read: one wait cycle, data registered for the second cycle
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = 32'd0;
        case (s_address)
            REG_CTRL:   rd_mux = {28'd0, irq_reg, irq_en_reg, busy, 1'b0};
            REG_PTR:    rd_mux = pointer_reg;
            REG_MATCH:  rd_mux = {16'd0, match_reg};
            REG_BMP_LO: rd_mux = bitmap_reg[31:0];
            REG_BMP_HI: rd_mux = bitmap_reg[63:32];
            default:    rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            rd_phase_reg <= 1'b0;
            rdata_reg    <= 32'd0;
        end else begin
            rd_phase_reg <= s_read && !rd_phase_reg;
            if (s_read && !rd_phase_reg) begin
                rdata_reg <= rd_mux;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address walk: row-major over the 8x8 block
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            addr_reg      <= 32'd0;
            row_base_reg  <= 32'd0;
            col_reg       <= 3'd0;
            issue_cnt_reg <= 7'd0;
            job_match_reg <= 16'd0;
        end else if (start_job) begin
            addr_reg      <= pointer_reg;
            row_base_reg  <= pointer_reg;
            col_reg       <= 3'd0;
            issue_cnt_reg <= 7'd0;
            job_match_reg <= match_reg;
        end else if (accept) begin
            issue_cnt_reg <= issue_cnt_reg + 7'd1;
            if (col_reg == 3'd7) begin
                row_base_reg <= row_base_reg + ROW_STEP;
                addr_reg     <= row_base_reg + ROW_STEP;
                col_reg      <= 3'd0;
            end else begin
                addr_reg <= addr_reg + 32'd2;
                col_reg  <= col_reg + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding / return tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            out_cnt_reg <= 4'd0;
            ret_cnt_reg <= 7'd0;
        end else if (start_job) begin
            out_cnt_reg <= 4'd0;
            ret_cnt_reg <= 7'd0;
        end else begin
            if (rvalid) begin
                ret_cnt_reg <= ret_cnt_reg + 7'd1;
            end
            case ({accept, rvalid})
                2'b10:   out_cnt_reg <= out_cnt_reg + 4'd1;
                2'b01:   out_cnt_reg <= out_cnt_reg - 4'd1;
                default: out_cnt_reg <= out_cnt_reg;
            endcase
        end
    end

    // one compare result per returned pixel, steered to its bit by the return index
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_bitmap
            assign bitmap_next[gi] = (rvalid && (ret_cnt_reg[5:0] == 6'(gi)))
                                     ? pix_hit : bitmap_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            bitmap_reg <= 64'd0;
        end else if (start_job) begin
            bitmap_reg <= 64'd0;
        end else begin
            bitmap_reg <= bitmap_next;
        end
    end

endmodule

// File: tb/tb_char_grab.sv
// Directed bench for char_grab with a pipelined memory responder and address/bitmap scoreboards.
module tb_char_grab;

    localparam int XRES    = 640;
    localparam int MAX_OUT = 4;

    logic        clock;
    logic        clock_areset_n;
    logic [3:0]  s_address;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        s_read;
    logic        s_write;
    logic        s_waitrequest;
    logic        s_irq;
    logic [31:0] m_address;
    logic [1:0]  m_byteenable;
    logic        m_read;
    logic [15:0] m_readdata;
    logic        m_readdatavalid;
    logic        m_waitrequest;

    char_grab #(.XRES(XRES), .MAX_OUT(MAX_OUT)) dut (
        .clock           (clock),
        .clock_areset_n  (clock_areset_n),
        .s_address       (s_address),
        .s_writedata     (s_writedata),
        .s_readdata      (s_readdata),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_waitrequest   (s_waitrequest),
        .s_irq           (s_irq),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_read          (m_read),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_waitrequest   (m_waitrequest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] data;
        int          ready;
    } resp_t;

    int          checks = 0;
    int          errors = 0;
    resp_t       pend[$];
    logic [31:0] exp_addr[$];
    logic [63:0] exp_bmp[$];
    logic [31:0] mem_base = 32'h1000;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          out_tb = 0;
    int          last_ready = 0;
    bit          rand_mode = 1'b0;
    bit          hold_pending = 1'b0;
    logic [31:0] hold_addr = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // framebuffer: 0xF800 on the diagonal of the 8x8 block at mem_base, 0 elsewhere
    function automatic logic [15:0] mem_word(input logic [31:0] a);
        logic [31:0] off;
        logic [31:0] x;
        logic [31:0] y;
        off = a - mem_base;
        y = off / 32'(2 * XRES);
        x = (off % 32'(2 * XRES)) / 32'd2;
        return (off[0] == 1'b0 && y < 8 && x < 8 && x == y) ? 16'hF800 : 16'h0000;
    endfunction

    // memory responder: random waitrequest, in-order responses with 1..6 cycle latency
    initial begin
        m_waitrequest   = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata      = 16'd0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!clock_areset_n) begin
                pend.delete();
                out_tb          = 0;
                last_ready      = 0;
                hold_pending    = 1'b0;
                m_readdatavalid = 1'b0;
                m_readdata      = 16'd0;
                m_waitrequest   = 1'b0;
                continue;
            end
            m_readdatavalid = 1'b0;
            m_readdata      = 16'd0;
            if (pend.size() > 0 && pend[0].ready <= cyc) begin
                m_readdatavalid = 1'b1;
                m_readdata      = pend[0].data;
                void'(pend.pop_front());
            end
            if (hold_pending) begin
                chk("hold_read", m_read, 1'b1);
                chk("hold_addr", m_address, hold_addr);
            end
            hold_pending  = 1'b0;
            m_waitrequest = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            if (m_read) begin
                chk("max_out", (out_tb < MAX_OUT), 1'b1);
                if (m_waitrequest) begin
                    hold_pending = 1'b1;
                    hold_addr    = m_address;
                end else begin
                    resp_t r;
                    int    lat;
                    chk("byteenable", m_byteenable, 2'b11);
                    checks++;
                    assert (exp_addr.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_read observed=%h expected=none", m_address);
                    end
                    if (exp_addr.size() != 0) begin
                        chk("rd_addr", m_address, exp_addr.pop_front());
                    end
                    lat = rand_mode ? int'($urandom_range(1, 6)) : 1;
                    r.ready = (cyc + lat > last_ready + 1) ? cyc + lat : last_ready + 1;
                    r.data  = mem_word(m_address);
                    last_ready = r.ready;
                    pend.push_back(r);
                    out_tb++;
                    acc_cnt++;
                end
            end
            if (m_readdatavalid) out_tb--;
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        #1;
        chk("wr_wait", s_waitrequest, 1'b0);
        @(posedge clock);
        #1;
        s_write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clock);
        s_address = a;
        s_read    = 1'b1;
        #1;
        chk("rd_wait1", s_waitrequest, 1'b1);
        @(posedge clock);
        #1;
        chk("rd_wait2", s_waitrequest, 1'b0);
        d = s_readdata;
        @(posedge clock);
        #1;
        s_read = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic start_job(input logic [31:0] ptr, input logic [15:0] match,
                             input bit irq_en, input bit program_regs);
        logic [63:0] bmp;
        mem_base = ptr;
        bmp = 64'd0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                logic [31:0] a;
                a = ptr + 32'(2 * x) + 32'(2 * XRES * y);
                exp_addr.push_back(a);
                bmp[y * 8 + x] = (mem_word(a) == match);
            end
        end
        exp_bmp.push_back(bmp);
        if (program_regs) begin
            bus_write(4'd1, ptr);
            bus_write(4'd2, {16'd0, match});
        end
        bus_write(4'd0, irq_en ? 32'h5 : 32'h1);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] d;
        bit          done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            bus_read(4'd0, d);
            if (!d[1]) done = 1'b1;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic finish_job(input string tag, output logic [63:0] got);
        logic [31:0] lo;
        logic [31:0] hi;
        wait_idle({tag, "_idle"});
        bus_read(4'd3, lo);
        bus_read(4'd4, hi);
        got = {hi, lo};
        chk({tag, "_issued"}, exp_addr.size(), 0);
        if (exp_bmp.size() != 0) chk({tag, "_bitmap"}, got, exp_bmp.pop_front());
    endtask

    task automatic wait_acc(input string tag, input int target);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clock);
            #2;
            if (acc_cnt >= target) hit = 1'b1;
        end
        chk(tag, hit, 1'b1);
    endtask

    initial begin
        logic [63:0] bmp;
        int          base;

        s_address = 4'd0; s_writedata = 32'd0; s_read = 1'b0; s_write = 1'b0;
        clock_areset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_m_read", m_read, 1'b0);
        chk("rst_m_addr", m_address, 32'd0);
        chk("rst_irq", s_irq, 1'b0);
        chk("rst_s_wait", s_waitrequest, 1'b0);
        chk("rst_s_rdata", s_readdata, 32'd0);
        clock_areset_n = 1'b1;
        read_chk("rst_ctrl", 4'd0, 32'd0);
        read_chk("rst_ptr", 4'd1, 32'd0);
        read_chk("rst_match", 4'd2, 32'd0);
        read_chk("rst_bmp_lo", 4'd3, 32'd0);
        read_chk("rst_bmp_hi", 4'd4, 32'd0);

        bus_write(4'd3, 32'hFFFF_FFFF);
        bus_write(4'd4, 32'hFFFF_FFFF);
        read_chk("ro_bmp_lo", 4'd3, 32'd0);
        read_chk("ro_bmp_hi", 4'd4, 32'd0);
        $display("step reset/ro regs checks=%0d errors=%0d", checks, errors);

        // basic job, no waitrequest, irq disabled
        rand_mode = 1'b0;
        start_job(32'h1000, 16'hF800, 1'b0, 1'b1);
        finish_job("jobA", bmp);
        chk("jobA_literal", bmp, 64'h8040_2010_0804_0201);
        read_chk("jobA_ctrl", 4'd0, 32'd0);
        read_chk("unmapped", 4'd7, 32'd0);
        $display("step jobA bitmap=%h checks=%0d errors=%0d", bmp, checks, errors);

        // random waitrequest and latency
        rand_mode = 1'b1;
        start_job(32'h1000, 16'hF800, 1'b0, 1'b1);
        finish_job("jobB", bmp);
        $display("step jobB bitmap=%h checks=%0d errors=%0d", bmp, checks, errors);

        // go while busy ignored; pointer/match writes only affect the next job
        base = acc_cnt;
        start_job(32'h1000, 16'hF800, 1'b0, 1'b1);
        wait_acc("jobC_acc", base + 10);
        bus_write(4'd0, 32'h1);
        bus_write(4'd1, 32'h2000);
        bus_write(4'd2, 32'h0000);
        read_chk("jobC_ptr_rb", 4'd1, 32'h2000);
        finish_job("jobC", bmp);
        start_job(32'h2000, 16'h0000, 1'b0, 1'b0);
        finish_job("jobD", bmp);
        chk("jobD_literal", bmp, 64'h7FBF_DFEF_F7FB_FDFE);
        $display("step jobC/D bitmap=%h checks=%0d errors=%0d", bmp, checks, errors);

        // irq set, then clear coinciding with a second completion
        rand_mode = 1'b0;
        start_job(32'h1000, 16'hF800, 1'b1, 1'b1);
        finish_job("jobE", bmp);
        read_chk("jobE_ctrl", 4'd0, 32'hC);
        base = acc_cnt;
        start_job(32'h1000, 16'hF800, 1'b1, 1'b0);
        wait_acc("jobF_acc", base + 64);
        bus_write(4'd5, 32'h1);
        chk("irq_clear_coincide", s_irq, 1'b1);
        finish_job("jobF", bmp);
        bus_write(4'd5, 32'h1);
        chk("irq_clear", s_irq, 1'b0);
        read_chk("jobF_ctrl", 4'd0, 32'h4);
        $display("step jobE/F irq checks=%0d errors=%0d", checks, errors);

        // reset mid-job
        rand_mode = 1'b1;
        base = acc_cnt;
        start_job(32'h1000, 16'hF800, 1'b0, 1'b1);
        wait_acc("jobG_acc", base + 20);
        clock_areset_n = 1'b0;
        #1;
        chk("abort_m_read", m_read, 1'b0);
        chk("abort_m_addr", m_address, 32'd0);
        exp_addr.delete();
        exp_bmp.delete();
        repeat (2) @(negedge clock);
        #2;
        clock_areset_n = 1'b1;
        read_chk("abort_ctrl", 4'd0, 32'd0);
        read_chk("abort_bmp_lo", 4'd3, 32'd0);
        read_chk("abort_bmp_hi", 4'd4, 32'd0);
        read_chk("abort_ptr", 4'd1, 32'd0);
        start_job(32'h1000, 16'hF800, 1'b0, 1'b1);
        finish_job("jobH", bmp);
        chk("jobH_literal", bmp, 64'h8040_2010_0804_0201);
        $display("step reset-abort/jobH bitmap=%h checks=%0d errors=%0d", bmp, checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
